// File: rtl/patch_matcher.sv
// 16x16 SAD template matcher: pipelined SAD, raster-order best-match search.
// Optional PATCH_MATCHER_THRESH_EN adds sad_thresh / match_found.
module patch_matcher #(
  parameter int POS_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0][15:0][7:0] template_data,
  input  logic                   template_load,
  input  logic [15:0][15:0][7:0] window_data,
  input  logic                   window_ready,
`ifdef PATCH_MATCHER_THRESH_EN
  input  logic [15:0]            sad_thresh,
  output logic                   match_found,
`endif
  output logic                   receive,
  output logic                   busy,
  output logic                   match_valid,
  output logic [15:0]            best_sad,
  output logic [6:0]             best_row,
  output logic [6:0]             best_col
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READY  = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;
  localparam logic [6:0] PMAX   = 7'(POS_MAX);

  logic [2:0]             state;
  logic [15:0][15:0][7:0] tmpl;
  logic [6:0]             row, col;
  logic                   last_pos;

  logic [15:0][15:0][7:0] ad;
  logic [15:0][15:0][7:0] d1;
  logic [15:0][11:0]      rsum;
  logic [15:0][11:0]      rs2;
  logic [15:0]            tot;
  logic [15:0]            sad3;

  logic                   v1, v2, v3;
  logic [6:0]             r1, c1, r2, c2, r3, c3;
  logic [15:0]            min_sad;
  logic [6:0]             min_row, min_col;

  assign receive     = window_ready && (state == READY || state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign match_valid = (state == REPORT);
  assign last_pos    = (row == PMAX) && (col == PMAX);

  always_comb begin
    ad = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        ad[r][c] = (window_data[r][c] > tmpl[r][c]) ?
                   window_data[r][c] - tmpl[r][c] :
                   tmpl[r][c] - window_data[r][c];
  end

  always_comb begin
    rsum = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        rsum[r] = rsum[r] + 12'(d1[r][c]);
  end

  always_comb begin
    tot = '0;
    for (int r = 0; r < 16; r++)
      tot = tot + 16'(rs2[r]);
  end

  always_ff @(posedge clk) begin
    if (template_load && (state == IDLE || state == READY))
      tmpl <= template_data;
    d1   <= ad;
    rs2  <= rsum;
    sad3 <= tot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      r1 <= '0;
      c1 <= '0;
      r2 <= '0;
      c2 <= '0;
      r3 <= '0;
      c3 <= '0;
    end else begin
      v1 <= receive;
      v2 <= v1;
      v3 <= v2;
      r1 <= row;
      c1 <= col;
      r2 <= r1;
      c2 <= c1;
      r3 <= r2;
      c3 <= c2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      min_sad  <= 16'hFFFF;
      min_row  <= '0;
      min_col  <= '0;
      best_sad <= '0;
      best_row <= '0;
      best_col <= '0;
`ifdef PATCH_MATCHER_THRESH_EN
      match_found <= 1'b0;
`endif
    end else begin
      // strict less-than keeps the earliest raster position on ties
      if (v3 && sad3 < min_sad) begin
        min_sad <= sad3;
        min_row <= r3;
        min_col <= c3;
      end
      unique case (state)
        IDLE: begin
          if (template_load) begin
            state   <= READY;
            row     <= '0;
            col     <= '0;
            min_sad <= 16'hFFFF;
          end
        end
        READY, RUN: begin
          if (receive) begin
            if (col == PMAX) begin
              col <= '0;
              row <= row + 7'd1;
            end else begin
              col <= col + 7'd1;
            end
            state <= last_pos ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          if (!v1 && !v2 && !v3) begin
            state    <= REPORT;
            best_sad <= min_sad;
            best_row <= min_row;
            best_col <= min_col;
`ifdef PATCH_MATCHER_THRESH_EN
            match_found <= (min_sad <= sad_thresh);
`endif
          end
        end
        REPORT: begin
          state   <= READY;
          row     <= '0;
          col     <= '0;
          min_sad <= 16'hFFFF;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_matcher.sv
// Directed bench for patch_matcher with a result scoreboard.
// Builds with or without PATCH_MATCHER_THRESH_EN.
module tb_patch_matcher;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [15:0][15:0][7:0] template_data;
  logic                   template_load;
  logic [15:0][15:0][7:0] window_data;
  logic                   window_ready;
  logic                   receive, busy, match_valid;
  logic [15:0]            best_sad;
  logic [6:0]             best_row, best_col;
`ifdef PATCH_MATCHER_THRESH_EN
  logic [15:0]            sad_thresh = 16'd0;
  logic                   match_found;
`endif

  always #5 clk = ~clk;

  patch_matcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .template_data (template_data),
    .template_load (template_load),
    .window_data   (window_data),
    .window_ready  (window_ready),
`ifdef PATCH_MATCHER_THRESH_EN
    .sad_thresh    (sad_thresh),
    .match_found   (match_found),
`endif
    .receive       (receive),
    .busy          (busy),
    .match_valid   (match_valid),
    .best_sad      (best_sad),
    .best_row      (best_row),
    .best_col      (best_col)
  );

  typedef struct {
    logic [15:0] sad;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        found;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int mv_cyc = 0;
  int rx_cnt = 0;
  int last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int s, input int r, input int c);
    exp_t e;
    e.sad   = 16'(s);
    e.row   = 7'(r);
    e.col   = 7'(c);
    e.found = (s <= 0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (receive) rx_cnt++;
    if (match_valid) begin
      mv_cnt++;
      mv_cyc = cyc;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("best_sad", 32'(best_sad), 32'(e.sad));
        check("best_row", 32'(best_row), 32'(e.row));
        check("best_col", 32'(best_col), 32'(e.col));
`ifdef PATCH_MATCHER_THRESH_EN
        check("match_found", 32'(match_found), 32'(e.found));
`endif
      end
    end
  end

  task automatic load_template(input logic [7:0] v);
    template_data = {256{v}};
    template_load = 1'b1;
    @(posedge clk); #1;
    template_load = 1'b0;
  endtask

  task automatic run_frame(input bit b2b, input logic [7:0] bg,
                           input int sr, input int sc,
                           input logic [7:0] sp, input int nwin,
                           input exp_t e, input bit push);
    for (int k = 0; k < nwin; k++) begin
      int r, c, w;
      r = k / 65;
      c = k % 65;
      window_data  = {256{(r == sr && c == sc) ? sp : bg}};
      window_ready = 1'b1;
      #1;
      w = 0;
      while (!receive && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      if (!receive) begin
        check("accept_timeout", 32'(receive), 32'd1);
        window_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      last_acc = cyc;
      if (!b2b) begin
        window_ready = 1'b0;
        @(posedge clk); #1;
      end
    end
    window_ready = 1'b0;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_match();
    int m0, w;
    m0 = mv_cnt;
    w = 0;
    while (mv_cnt == m0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("match_pulses", 32'(mv_cnt - m0), 32'd1);
  endtask

  initial begin
    int rx0;
    rst_n         = 1'b0;
    template_load = 1'b0;
    template_data = '0;
    window_data   = '0;
    window_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_receive", 32'(receive), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_match_valid", 32'(match_valid), 32'd0);
    check("rst_best_sad", 32'(best_sad), 32'd0);
    check("rst_best_row", 32'(best_row), 32'd0);
    check("rst_best_col", 32'(best_col), 32'd0);
`ifdef PATCH_MATCHER_THRESH_EN
    check("rst_match_found", 32'(match_found), 32'd0);
`endif
    window_ready = 1'b0;

    load_template(8'h00);
    run_frame(0, 8'h10, 10, 20, 8'h00, 4225, mk(0, 10, 20), 1);
    wait_match();
    check("idle_busy", 32'(busy), 32'd0);

    run_frame(0, 8'h01, -1, -1, 8'h00, 4225, mk(256, 0, 0), 1);
    wait_match();

    run_frame(0, 8'hFF, -1, -1, 8'h00, 4225, mk(65280, 0, 0), 1);
    wait_match();
    check("max_hold", 32'(best_sad), 32'hFF00);

    load_template(8'h20);
    rx0 = rx_cnt;
    run_frame(1, 8'h30, 64, 64, 8'h21, 4225, mk(256, 64, 64), 1);
    check("b2b_rx", 32'(rx_cnt - rx0), 32'd4225);
    wait_match();
    check("b2b_latency", 32'(mv_cyc - last_acc), 32'd4);

    run_frame(1, 8'h30, 33, 7, 8'h22, 4225, mk(512, 33, 7), 1);
    rx0 = rx_cnt;
    window_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 window_ready = 1'b0;
    check("drain_no_accept", 32'(rx_cnt - rx0), 32'd0);
    wait_match();
    check("frame2_hold_sad", 32'(best_sad), 32'd512);

    run_frame(0, 8'h00, 5, 5, 8'h06, 1000, mk(0, 0, 0), 0);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_best_sad", 32'(best_sad), 32'd0);
    check("abort_best_row", 32'(best_row), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    window_ready = 1'b1;
    #1;
    check("abort_receive", 32'(receive), 32'd0);
    window_ready = 1'b0;
    @(posedge clk); #1;
    load_template(8'h05);
    run_frame(0, 8'h00, 5, 5, 8'h06, 4225, mk(256, 5, 5), 1);
    wait_match();

    check("total_matches", 32'(mv_cnt), 32'd6);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/patch_matcher.md
# patch_matcher

- Downstream consumer of `window_handler`: receives one 16x16 byte window per handshake from the 80x80 search area.
- Computes the sum of absolute differences (SAD) between each window and a latched 16x16 template.
- Tracks the minimum SAD and its window position over all 65x65 positions in a frame, then reports the best match with a one-cycle pulse.
- Pipelined, so it accepts a window every cycle, though the upstream handler delivers at most one every two cycles.

## Interface
Parameters:
- `POS_MAX`, default 64: last window offset on each axis; positions run 0..`POS_MAX`.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `template_data`  in  [15:0][15:0][7:0]  template pixels, `[row][col]`.
- `template_load`  in  1  latch `template_data` (honoured only in IDLE/READY).
- `window_data`  in  [15:0][15:0][7:0]  window pixels from `window_handler`.
- `window_ready`  in  1  `window_data` valid this cycle.
- `receive`  out  1  combinational: window accepted this cycle.
- `busy`  out  1  state is RUN or DRAIN.
- `match_valid`  out  1  one-cycle pulse; frame result valid.
- `best_sad`  out  16  minimum SAD of the last completed frame.
- `best_row`, `best_col`  out  7 each  offset of that window.

## Operation
- States: IDLE, READY, RUN, DRAIN, REPORT.
- IDLE:
  - No template is held.
  - `template_load` latches the template and moves to READY.
  - `window_ready` is ignored and `receive`=0.
- READY:
  - Template is held, the position counter is (0,0) and the running minimum is 0xFFFF.
  - `template_load` re-latches the template and stays in READY.
  - An accepted window moves to RUN.
- RUN:
  - `template_load` is ignored.
  - Each accepted window takes the current position, then the counter advances: col+1; when col==`POS_MAX`, col=0 and row+1.
  - Accepting position (`POS_MAX`,`POS_MAX`) moves to DRAIN.
- DRAIN:
  - No acceptance.
  - Waits until the final window's compare has completed, then moves to REPORT.
- REPORT:
  - Lasts one cycle with `match_valid`=1.
  - Then moves to READY with the template retained, the counter cleared and the running minimum reset to 0xFFFF.
- `receive` = `window_ready` && (state==READY || state==RUN).
- Pipeline, 3 register stages plus compare. Each stage carries a valid bit and the (row,col) tag.
  - S1: 256 absolute differences, 8 bits each.
  - S2: 16 row sums, 12 bits each.
  - S3: total SAD, 16 bits. The maximum is 256*255 = 65280, so there is no overflow.
  - Compare: update the running minimum only if SAD < running minimum (strict). Ties therefore keep the earliest raster position.
- Output registers `best_sad`/`best_row`/`best_col` load from the running minimum, including the final window, on the edge that raises `match_valid`. They hold until the next frame reports.

## Timing
- Reset values:
  - State IDLE; `match_valid`=0, `busy`=0, `best_sad`=0, `best_row`=0, `best_col`=0.
  - All pipeline valids 0; running minimum 0xFFFF; counter (0,0).
  - `receive`=0, because it is gated by IDLE.
- Acceptance at edge E0 registers S1. S2 registers at E1, S3 at E2, and the compare updates the running minimum at E3.
- For the final window accepted at E0:
  - `match_valid` and the output registers assert at E4, for one cycle.
  - State returns to READY at E5.
- `busy` deasserts with REPORT.
- Reset asserted mid-frame:
  - Immediately returns to IDLE and clears all pipeline valids and outputs.
  - The template must be reloaded.
  - No `match_valid` is produced for the aborted frame.
- A `window_ready` held high across DRAIN/REPORT is not accepted. Upstream holds or drops it and is not consumed.

## Configuration
- `PATCH_MATCHER_THRESH_EN` defined:
  - Adds input `sad_thresh` [15:0] and output `match_found` (1 bit, reset 0).
  - `match_found` is registered with `match_valid`: it equals (final `best_sad` <= `sad_thresh`) and holds until the next report.
- Not defined: both ports are absent and no comparison logic is generated.

## Test plan
- Reset: drive `rst_n`=0, then release → all outputs 0 and `receive`=0 even with `window_ready`=1 and no template.
- Exact match:
  - Stimulus: template all 0x00; windows all 0x10 except position (10,20), which is all 0x00; 4225 windows sent at one every 2 cycles.
  - Required: `match_valid` pulses once; `best_sad`=0, `best_row`=10, `best_col`=20.
- Ties: all windows give SAD 256 (template 0x00, windows 0x01) → `best_sad`=256 at (0,0).
- Maximum: template 0x00, windows 0xFF → `best_sad`=65280 (0xFF00) at (0,0), no wrap.
- Back-to-back throughput:
  - Stimulus: `window_ready` held high for 4225 cycles.
  - Required: `receive` is high for exactly 4225 cycles; `match_valid` rises 4 edges after the last accept; a second frame is then accepted without reloading the template.
- Reset mid-frame:
  - Stimulus: after 1000 windows, pulse `rst_n` low, reload the template, then run a full frame.
  - Required: exactly one `match_valid` (for the new frame), with correct values.
  - With `PATCH_MATCHER_THRESH_EN`, `sad_thresh`=0 → `match_found`=1 in the exact-match case and 0 in the ties case.
